// File: rtl/k12a_spi_master.sv
// Multi-channel SPI master: one active bus at a time, CPOL/CPHA modes, MSB/LSB order, programmable SCK divider.
// Latency: busy for (div+1)*(2*DATA_WIDTH+2) cycles after start, then a one-cycle done pulse.
// Backpressure: none; start is taken only in IDLE (including the done cycle), otherwise it is dropped.
module k12a_spi_master #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  cpu_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CH_W-1:0]       channel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [CHANNELS-1:0]   spi_sck,
  output logic [CHANNELS-1:0]   spi_mosi,
  output logic [CHANNELS-1:0]   spi_cs_n,
  input  logic [CHANNELS-1:0]   spi_miso
);

  // Edge counter must hold 0 .. 2*DATA_WIDTH-1.
  localparam int ECW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } mode_t;

  state_t                state;
  mode_t                 mode_q;
  logic [CH_W-1:0]       ch_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [ECW-1:0]        edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  // Single-lane pin state for the latched channel; fanned out below.
  logic                  sck_r;
  logic                  mosi_r;
  logic                  cs_n_r;

  logic ch_ok;
  logic cnt_zero;
  logic sh_leading;
  logic sh_last;
  logic sh_sample;
  logic sh_drive;
  logic miso_bit;

  // Bit presented next on MOSI, depending on bit order.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  // Moves the next bit to the head position.
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign ch_ok      = ({1'b0, channel} < CH_LIMIT);
  assign cnt_zero   = (cnt == '0);
  // edge_cnt holds the number of edges already issued, so the next edge is odd (leading) when it is even.
  assign sh_leading = ~edge_cnt[0];
  assign sh_last    = (edge_cnt == ECW'(2 * DATA_WIDTH - 1));
  assign sh_sample  = sh_leading ^ mode_q.cpha;
  // With cpha=0 the first bit is already on MOSI from SETUP and the final trailing edge drives nothing.
  assign sh_drive   = mode_q.cpha ? sh_leading : (~sh_leading & ~sh_last);
  assign miso_bit   = spi_miso[ch_q];

  // Transfer sequencer: owns the state, divider, shift registers and the single-lane pin registers.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      mode_q   <= '0;
      ch_q     <= '0;
      div_q    <= '0;
      cnt      <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      sck_r    <= 1'b0;
      mosi_r   <= 1'b0;
      cs_n_r   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state  <= IDLE;
        busy   <= 1'b0;
        cs_n_r <= 1'b1;
        sck_r  <= mode_q.cpol;
        mosi_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && ch_ok) begin
              state    <= SETUP;
              busy     <= 1'b1;
              ch_q     <= channel;
              mode_q   <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
              div_q    <= div;
              cnt      <= div;
              edge_cnt <= '0;
              rx_sh    <= '0;
              cs_n_r   <= 1'b0;
              sck_r    <= cpol;
              if (!cpha) begin
                mosi_r <= head_bit(tx_data, lsb_first);
                tx_sh  <= advance(tx_data, lsb_first);
              end else begin
                mosi_r <= 1'b0;
                tx_sh  <= tx_data;
              end
            end
          end
          SETUP: begin
            if (cnt_zero) begin
              state <= SHIFT;
              cnt   <= div_q;
            end else begin
              cnt <= cnt - DIV_WIDTH'(1);
            end
          end
          SHIFT: begin
            if (!cnt_zero) begin
              cnt <= cnt - DIV_WIDTH'(1);
            end else begin
              cnt      <= div_q;
              sck_r    <= ~sck_r;
              edge_cnt <= edge_cnt + ECW'(1);
              if (sh_sample) begin
                rx_sh <= mode_q.lsb_first ? {miso_bit, rx_sh[DATA_WIDTH-1:1]}
                                          : {rx_sh[DATA_WIDTH-2:0], miso_bit};
              end
              if (sh_drive) begin
                mosi_r <= head_bit(tx_sh, mode_q.lsb_first);
                tx_sh  <= advance(tx_sh, mode_q.lsb_first);
              end
              if (sh_last) begin
                state <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!cnt_zero) begin
              cnt <= cnt - DIV_WIDTH'(1);
            end else begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              rx_data <= rx_sh;
              cs_n_r  <= 1'b1;
              mosi_r  <= 1'b0;
              sck_r   <= mode_q.cpol;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Pin fan-out: only the latched channel follows the lane registers, the rest sit at idle levels.
  always_comb begin
    spi_sck  = {CHANNELS{mode_q.cpol}};
    spi_mosi = '0;
    spi_cs_n = '1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == CH_W'(i)) begin
        spi_sck[i]  = sck_r;
        spi_mosi[i] = mosi_r;
        spi_cs_n[i] = cs_n_r;
      end
    end
  end

endmodule

// File: tb/tb_k12a_spi_master.sv
// Bench for k12a_spi_master: two instances (4ch x 8b, 3ch x 16b) driven by a pin-level SPI slave.
// Expected rx words are queued at start and popped on done; slave-side capture checks MOSI.
// Runs a fixed directed sequence and prints one summary line.
module tb_k12a_spi_master;

  logic cpu_clock = 1'b0;
  logic reset = 1'b0;
  always #5 cpu_clock = ~cpu_clock;

  int checks = 0;
  int errors = 0;

  // Instance A: 4 channels, 8-bit words, 4-bit divider
  logic       a_start = 0, a_abort = 0, a_cpol = 0, a_cpha = 0, a_lsb = 0;
  logic [1:0] a_ch = 0;
  logic [3:0] a_div = 0;
  logic [7:0] a_tx = 0;
  logic       a_busy, a_done;
  logic [7:0] a_rx;
  logic [3:0] a_sck, a_mosi, a_cs_n, a_miso;

  // Instance B: 3 channels, 16-bit words, 8-bit divider
  logic        b_start = 0, b_abort = 0, b_cpol = 0, b_cpha = 0, b_lsb = 0;
  logic [1:0]  b_ch = 0;
  logic [7:0]  b_div = 0;
  logic [15:0] b_tx = 0;
  logic        b_busy, b_done;
  logic [15:0] b_rx;
  logic [2:0]  b_sck, b_mosi, b_cs_n, b_miso;

  k12a_spi_master #(.CHANNELS(4), .DATA_WIDTH(8), .DIV_WIDTH(4)) dut_a (
    .cpu_clock(cpu_clock), .reset(reset), .start(a_start), .abort(a_abort), .channel(a_ch),
    .cpol(a_cpol), .cpha(a_cpha), .lsb_first(a_lsb), .div(a_div), .tx_data(a_tx),
    .busy(a_busy), .done(a_done), .rx_data(a_rx),
    .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_cs_n(a_cs_n), .spi_miso(a_miso)
  );

  k12a_spi_master #(.CHANNELS(3), .DATA_WIDTH(16), .DIV_WIDTH(8)) dut_b (
    .cpu_clock(cpu_clock), .reset(reset), .start(b_start), .abort(b_abort), .channel(b_ch),
    .cpol(b_cpol), .cpha(b_cpha), .lsb_first(b_lsb), .div(b_div), .tx_data(b_tx),
    .busy(b_busy), .done(b_done), .rx_data(b_rx),
    .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_cs_n(b_cs_n), .spi_miso(b_miso)
  );

  // Selection of the instance under test and the slave model state
  bit          sel = 0;
  bit          loop_a = 0;
  int          sl_ch = 0, sl_w = 8;
  bit          sl_cpha = 0, sl_lsb = 0;
  logic [15:0] sl_word = 0, sl_rx = 0;
  int          sl_bit = 0, sl_edges = 0, sl_samples = 0;
  logic        sl_miso = 0, sl_first = 0, sl_last = 0;
  logic        prev_cs = 1, prev_sck = 0;
  logic        cur_pol = 0;
  int          iso_bad = 0;
  logic [15:0] last_rx = 0;
  logic [15:0] exp_q[$];

  logic        cur_busy, cur_done;
  logic [15:0] cur_rx;
  logic [3:0]  cur_cs, cur_sck, cur_mosi;
  assign cur_busy = sel ? b_busy : a_busy;
  assign cur_done = sel ? b_done : a_done;
  assign cur_rx   = sel ? b_rx : {8'h00, a_rx};
  assign cur_cs   = sel ? {1'b1, b_cs_n} : a_cs_n;
  assign cur_sck  = sel ? {1'b0, b_sck} : a_sck;
  assign cur_mosi = sel ? {1'b0, b_mosi} : a_mosi;

  assign a_miso = loop_a ? {3'b000, a_mosi[0]} : ((!sel && sl_miso) ? (4'b0001 << sl_ch) : 4'b0000);
  assign b_miso = (sel && sl_miso) ? (3'b001 << sl_ch) : 3'b000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  // Slave: presents bits on its drive edges, captures MOSI on its sample edges
  task slave_drive();
    if (sl_bit < sl_w) sl_miso = sl_word[sl_lsb ? sl_bit : (sl_w - 1 - sl_bit)];
    sl_bit++;
  endtask

  task slave_sample();
    logic m;
    m = cur_mosi[sl_ch];
    if (sl_samples == 0) sl_first = m;
    sl_last = m;
    sl_samples++;
    if (sl_lsb) sl_rx = (sl_rx >> 1) | (16'(m) << (sl_w - 1));
    else        sl_rx = ((sl_rx << 1) | 16'(m)) & 16'((32'd1 << sl_w) - 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge cpu_clock);
      if (prev_cs === 1'b1 && cur_cs[sl_ch] === 1'b0) begin
        sl_edges = 0; sl_rx = '0; sl_bit = 0; sl_samples = 0;
        if (!sl_cpha) slave_drive();
      end else if (cur_cs[sl_ch] === 1'b0 && cur_sck[sl_ch] !== prev_sck) begin
        sl_edges++;
        if (((sl_edges % 2) == 1) != sl_cpha) slave_sample();
        else slave_drive();
      end
      prev_cs  = cur_cs[sl_ch];
      prev_sck = cur_sck[sl_ch];
    end
  end

  task automatic launch(input bit d, input int ch, input bit pol, input bit pha, input bit lsb,
                        input int dv, input logic [15:0] tx, input logic [15:0] sw, input int w);
    sel = d; sl_ch = ch; sl_cpha = pha; sl_lsb = lsb; sl_word = sw; sl_w = w;
    cur_pol = pol; iso_bad = 0;
    exp_q.push_back(loop_a ? tx : sw);
    if (!d) begin
      a_ch = 2'(ch); a_cpol = pol; a_cpha = pha; a_lsb = lsb; a_div = 4'(dv); a_tx = tx[7:0]; a_start = 1;
    end else begin
      b_ch = 2'(ch); b_cpol = pol; b_cpha = pha; b_lsb = lsb; b_div = 8'(dv); b_tx = tx; b_start = 1;
    end
  endtask

  task automatic release_start();
    a_start = 0;
    b_start = 0;
  endtask

  // Counts busy samples (starting from 'already'), then checks busy length, done and rx against the queue
  task automatic wait_done(input string tag, input int exp_busy, input int already);
    int n;
    logic [15:0] e;
    n = already;
    while (cur_busy === 1'b1 && n < 4000) begin
      if (!sel)
        for (int i = 0; i < 4; i++)
          if (i != sl_ch && (a_cs_n[i] !== 1'b1 || a_sck[i] !== cur_pol || a_mosi[i] !== 1'b0)) iso_bad++;
      tick();
      n++;
    end
    check({tag, " busy cycles"}, n, exp_busy);
    check({tag, " done"}, cur_done, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, " rx_data"}, cur_rx, e);
    last_rx = e;
  endtask

  task automatic finish_checks(input string tag, input logic [15:0] tx, input int w, input bit post_tick);
    check({tag, " sck edges"}, sl_edges, 2 * w);
    check({tag, " mosi word"}, sl_rx, tx);
    check({tag, " cs_n high"}, cur_cs[sl_ch], 1'b1);
    check({tag, " sck idle"}, cur_sck[sl_ch], cur_pol);
    if (!sel) check({tag, " isolation"}, iso_bad, 0);
    if (post_tick) begin
      tick();
      check({tag, " done width"}, cur_done, 1'b0);
    end
  endtask

  task automatic run_xfer(input string tag, input bit d, input int ch, input bit pol, input bit pha,
                          input bit lsb, input int dv, input logic [15:0] tx, input logic [15:0] sw,
                          input int w);
    launch(d, ch, pol, pha, lsb, dv, tx, sw, w);
    tick();
    release_start();
    check({tag, " cs_n low"}, cur_cs[ch], 1'b0);
    wait_done(tag, (dv + 1) * (2 * w + 2), 0);
    finish_checks(tag, tx, w, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    // Async reset: outputs take reset values before any clock edge
    #1 reset = 1'b1;
    #2;
    check("reset busy", a_busy, 1'b0);
    check("reset done", a_done, 1'b0);
    check("reset rx", a_rx, 8'h00);
    check("reset sck", a_sck, 4'h0);
    check("reset mosi", a_mosi, 4'h0);
    check("reset cs_n", a_cs_n, 4'hF);
    check("reset b cs_n", b_cs_n, 3'b111);
    @(negedge cpu_clock);
    reset = 1'b0;
    tick();

    // Loopback, mode 0, div 0
    loop_a = 1;
    launch(0, 0, 0, 0, 0, 0, 16'h00A5, 16'h00A5, 8);
    tick();
    release_start();
    check("loop cs fall", a_cs_n, 4'b1110);
    wait_done("loop", 18, 0);
    finish_checks("loop", 16'h00A5, 8, 1'b1);
    loop_a = 0;

    // All four modes, div 2, slave answers 0xC3
    for (int m = 0; m < 4; m++) begin
      run_xfer($sformatf("mode%0d", m), 0, 1, m[1], m[0], 0, 2, 16'h003C, 16'h00C3, 8);
      check($sformatf("mode%0d idle sck", m), a_sck, {4{m[1]}});
    end

    // LSB first, 8-bit and 16-bit
    run_xfer("lsb8", 0, 3, 0, 0, 1, 0, 16'h001E, 16'h004B, 8);
    run_xfer("lsb16", 1, 0, 0, 0, 1, 0, 16'h8001, 16'h1234, 16);
    check("lsb16 first bit", sl_first, 1'b1);
    check("lsb16 last bit", sl_last, 1'b1);
    run_xfer("lsb16 m1", 1, 2, 0, 1, 1, 1, 16'h1F02, 16'hC35A, 16);
    run_xfer("msb16 m3", 1, 1, 1, 1, 0, 0, 16'hBEEF, 16'h0F0E, 16);

    // Out-of-range channel on the 3-channel instance is ignored
    sel = 1; b_ch = 2'd3; b_start = 1;
    tick();
    b_start = 0;
    check("bad channel busy", b_busy, 1'b0);
    check("bad channel cs_n", b_cs_n, 3'b111);
    repeat (3) tick();
    check("bad channel still idle", b_busy, 1'b0);

    // Channel isolation with cpol=1 on channel 2
    run_xfer("iso", 0, 2, 1, 1, 0, 1, 16'h0096, 16'h0069, 8);

    // Start while busy is dropped
    launch(0, 0, 0, 0, 0, 0, 16'h0055, 16'h000F, 8);
    tick();
    release_start();
    repeat (4) tick();
    a_start = 1; a_tx = 8'hFF; a_ch = 2'd1;
    tick();
    a_start = 0;
    wait_done("ignored start", 18, 5);
    finish_checks("ignored start", 16'h0055, 8, 1'b1);
    repeat (3) tick();
    check("no queued transfer", a_busy, 1'b0);

    // Start on the done cycle: back-to-back with one idle cycle of cs_n
    launch(0, 1, 0, 0, 0, 0, 16'h0012, 16'h0034, 8);
    tick();
    release_start();
    wait_done("b2b first", 18, 0);
    finish_checks("b2b first", 16'h0012, 8, 1'b0);
    launch(0, 1, 0, 0, 0, 0, 16'h009A, 16'h007E, 8);
    tick();
    release_start();
    check("b2b second cs_n", a_cs_n[1], 1'b0);
    check("b2b second busy", a_busy, 1'b1);
    wait_done("b2b second", 18, 0);
    finish_checks("b2b second", 16'h009A, 8, 1'b1);

    // Abort in cycle 7 (mode 3): idle next cycle, no done, rx unchanged
    launch(0, 0, 1, 1, 0, 1, 16'h00F0, 16'h000F, 8);
    tick();
    release_start();
    repeat (6) tick();
    a_abort = 1;
    tick();
    a_abort = 0;
    exp_q.delete();
    check("abort busy", a_busy, 1'b0);
    check("abort cs_n", a_cs_n, 4'hF);
    check("abort sck", a_sck, 4'hF);
    done_seen = 0;
    repeat (40) begin
      if (a_done !== 1'b0 || a_busy !== 1'b0) done_seen++;
      tick();
    end
    check("abort no done", done_seen, 0);
    check("abort rx kept", a_rx, last_rx[7:0]);

    // Abort together with start in IDLE: start wins
    a_abort = 1;
    launch(0, 0, 0, 0, 0, 0, 16'h003C, 16'h00A7, 8);
    tick();
    release_start();
    a_abort = 0;
    check("abort+start busy", a_busy, 1'b1);
    wait_done("abort+start", 18, 0);
    finish_checks("abort+start", 16'h003C, 8, 1'b1);

    // Largest divider: 16 cycles per half-period
    run_xfer("div max", 0, 1, 0, 1, 0, 15, 16'h00C6, 16'h0039, 8);

    // Async reset in SHIFT, between edges
    launch(0, 3, 1, 0, 0, 0, 16'h005A, 16'h00C3, 8);
    tick();
    release_start();
    repeat (6) tick();
    #3 reset = 1'b1;
    #1;
    check("mid reset busy", a_busy, 1'b0);
    check("mid reset cs_n", a_cs_n, 4'hF);
    check("mid reset sck", a_sck, 4'h0);
    check("mid reset rx", a_rx, 8'h00);
    check("mid reset done", a_done, 1'b0);
    exp_q.delete();
    last_rx = 0;
    @(negedge cpu_clock);
    reset = 1'b0;
    tick();
    run_xfer("after reset", 0, 3, 0, 0, 0, 0, 16'h0081, 16'h007E, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
